// File: rtl/lsc_pkg.sv
// Shared funct3 codes, FSM encoding and access-decode helpers for the load/store controller.
// Pure definitions, no latency; no flow control of its own.
package lsc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsc_state_t;

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic lsc_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic illegal;
    logic misaligned;
    if (we) illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else    illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return illegal || misaligned;
  endfunction

  function automatic logic [3:0] lsc_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsc_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsc_load_align.sv
// Load lane select and sign/zero extension of a memory word.
// Combinational, zero latency; no flow control.
module lsc_load_align
  import lsc_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_rdata[8*addr +: 8];
    half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_B:    rdata = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   rdata = {24'd0, byte_lane};
      F3_H:    rdata = {{16{half_lane[15]}}, half_lane};
      F3_HU:   rdata = {16'd0, half_lane};
      default: rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Multi-cycle load/store sequencer to a req/ack word memory; LSC_TIMEOUT_EN adds an ack timeout.
// Latency: accept -> mem_req next cycle, mem_ack -> rsp_valid next cycle; errors respond 1 cycle after accept.
// Backpressure: req_ready only in IDLE; memory stalls by withholding mem_ack; response is never stalled.
module load_store_ctrl
  import lsc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsc_state_t  state, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic [31:0] rd_q;
  logic        err_q;
  logic [31:0] align_rdata;
  logic        expire;

  lsc_load_align u_align (
    .funct3    (f3_q),
    .addr      (a_q),
    .mem_rdata (mem_rdata),
    .rdata     (align_rdata)
  );

`ifdef LSC_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // mem_ack in the expiry cycle wins, so expiry requires no ack.
  assign expire = (state == ACCESS) && !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tmo_cnt <= '0;
    else if (state != ACCESS)  tmo_cnt <= '0;
    else if (!mem_ack)         tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{TIMEOUT_CYCLES, TMO_W};
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid) state_d = lsc_bad(req_we, req_funct3, req_addr[1:0]) ? RESP : ACCESS;
      ACCESS:  if (mem_ack || expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      a_q       <= 2'd0;
      rd_q      <= 32'd0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q  <= req_we;
          f3_q  <= req_funct3;
          a_q   <= req_addr[1:0];
          rd_q  <= 32'd0;
          err_q <= lsc_bad(req_we, req_funct3, req_addr[1:0]);
          if (!lsc_bad(req_we, req_funct3, req_addr[1:0])) begin
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= lsc_be(req_funct3, req_addr[1:0]);
            mem_wdata <= lsc_wdata(req_funct3, req_wdata);
          end
        end
        ACCESS: if (mem_ack) begin
          rd_q  <= we_q ? 32'd0 : align_rdata;
          err_q <= 1'b0;
        end else if (expire) begin
          rd_q  <= 32'd0;
          err_q <= 1'b1;
        end
        default: begin
          rd_q  <= 32'd0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_req   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rd_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl; define LSC_TIMEOUT_EN to also exercise the ack timeout.
module tb_load_store_ctrl;
  import lsc_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_ctrl #(.TIMEOUT_CYCLES(16), .TMO_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
  endtask

  // Legal access: memory acks after 'waits' idle ACCESS cycles.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
    issue(we, f3, addr, wdata);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
    if (we) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    chk({tag, "_busy"}, {30'd0, busy, req_ready}, 32'd2);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, "_wait_req"}, {30'd0, mem_req, rsp_valid}, 32'd2);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid, mem_req}, 32'd2);
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    tick();
    chk({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic bad_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
    issue(we, f3, addr, 32'hFFFF_FFFF);
    chk({tag, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    tick();
    chk({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ctl", {28'd0, busy, mem_req, rsp_valid, rsp_err}, 32'd0);
    chk("rst_mem", {27'd0, mem_we, mem_be}, 32'd0);
    chk("rst_addr", mem_addr | mem_wdata | rsp_rdata, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    access("lw100", 1'b0, F3_W, 32'h100, 32'd0, 3, 32'hDEAD_BEEF, 4'b1111, 32'd0, 32'hDEAD_BEEF);
    access("lb103", 1'b0, F3_B, 32'h103, 32'd0, 1, 32'h80FF_1234, 4'b1000, 32'd0, 32'hFFFF_FF80);
    access("lbu103", 1'b0, F3_BU, 32'h103, 32'd0, 0, 32'h80FF_1234, 4'b1000, 32'd0, 32'h0000_0080);
    access("lbu101", 1'b0, F3_BU, 32'h101, 32'd0, 0, 32'h80FF_1234, 4'b0010, 32'd0, 32'h0000_0012);
    access("lh002", 1'b0, F3_H, 32'h2, 32'd0, 2, 32'h8001_7FFF, 4'b1100, 32'd0, 32'hFFFF_8001);
    access("lh000", 1'b0, F3_H, 32'h0, 32'd0, 0, 32'h8001_7FFF, 4'b0011, 32'd0, 32'h0000_7FFF);
    access("sh202", 1'b1, F3_H, 32'h202, 32'h0000_ABCD, 0, 32'h1234_5678, 4'b1100, 32'hABCD_ABCD, 32'd0);
    access("sb301", 1'b1, F3_B, 32'h301, 32'h1234_56A5, 1, 32'd0, 4'b0010, 32'hA5A5_A5A5, 32'd0);
    access("sw400", 1'b1, F3_W, 32'h400, 32'hCAFE_F00D, 0, 32'd0, 4'b1111, 32'hCAFE_F00D, 32'd0);

    bad_access("lw101", 1'b0, F3_W, 32'h101);
    bad_access("f3_011", 1'b0, 3'b011, 32'h100);
    bad_access("sbu", 1'b1, F3_BU, 32'h100);
    bad_access("lh003", 1'b0, F3_H, 32'h3);
    bad_access("sw102", 1'b1, F3_W, 32'h102);

    // Reset mid-access: request must drop at once and the abandoned access must not respond.
    issue(1'b0, F3_W, 32'h10, 32'd0);
    chk("mid_rst_pre_req", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_ready", {30'd0, req_ready, busy}, 32'd2);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    reset_n = 1'b1;
    tick();
    chk("stray_ack_1", {30'd0, rsp_valid, busy}, 32'd0);
    tick();
    chk("stray_ack_2", {30'd0, rsp_valid, busy}, 32'd0);
    mem_ack = 1'b0;
    access("lhu006", 1'b0, F3_HU, 32'h6, 32'd0, 1, 32'h8001_0000, 4'b1100, 32'd0, 32'h0000_8001);

`ifdef LSC_TIMEOUT_EN
    begin
      int cnt;
      issue(1'b0, F3_W, 32'h500, 32'd0);
      cnt = 0;
      while (mem_req && cnt < 40) begin
        cnt++;
        tick();
      end
      chk("tmo_req_cycles", cnt, 32'd16);
      chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("tmo_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
      tick();
      chk("tmo_done", {30'd0, rsp_valid, req_ready}, 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
